// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store formatter around one data-cache port; define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic op_load, op_byte, op_half, op_uns;
    logic [1:0] op_off;
    logic accept, is_store, is_byte, is_half, mis;
    logic [3:0] fmt_mask;
    logic [31:0] fmt_wdata, ld_data;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    assign req_ready = state != ACCESS;
    assign accept = req_ready && req_valid && (req_load || req_store);
    assign is_store = req_store;
    assign is_byte = is_store ? req_funct3 == 3'b000 : req_funct3[1:0] == 2'b00;
    assign is_half = is_store ? req_funct3 == 3'b001 : req_funct3[1:0] == 2'b01;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (is_half && req_addr[0]) || (!is_byte && !is_half && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign fmt_mask = is_byte ? 4'b0001 << req_addr[1:0] : is_half ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
    assign fmt_wdata = is_byte ? {4{req_wdata[7:0]}} : is_half ? {2{req_wdata[15:0]}} : req_wdata;
    assign ld_byte = dmem_rdata[{op_off, 3'b000} +: 8];
    assign ld_half = dmem_rdata[{op_off[1], 4'b0000} +: 16];
    assign ld_data = op_byte ? {{24{!op_uns && ld_byte[7]}}, ld_byte}
                   : op_half ? {{16{!op_uns && ld_half[15]}}, ld_half} : dmem_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // Next state: accepted ops issue (or trap straight to RESP), ACCESS waits for the cache
    always_comb begin
        state_nx = state;
        if (accept) state_nx = mis ? RESP : ACCESS;
        else if (state == ACCESS) state_nx = dmem_resp ? RESP : ACCESS;
        else if (state == RESP) state_nx = IDLE;
    end

    // Registered cache strobes, latched op attributes and formatted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_address    <= 32'b0;
            dmem_read       <= 1'b0;
            dmem_write      <= 1'b0;
            dmem_wmask      <= 4'b0;
            dmem_wdata      <= 32'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'b0;
            resp_misaligned <= 1'b0;
            op_load         <= 1'b0;
            op_byte         <= 1'b0;
            op_half         <= 1'b0;
            op_uns          <= 1'b0;
            op_off          <= 2'b0;
        end else begin
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            if (accept && !mis) begin
                dmem_address <= {req_addr[31:2], 2'b00};
                dmem_read    <= !is_store;
                dmem_write   <= is_store;
                dmem_wmask   <= is_store ? fmt_mask : 4'b0;
                dmem_wdata   <= is_store ? fmt_wdata : 32'b0;
                op_load      <= !is_store;
                op_byte      <= is_byte;
                op_half      <= is_half;
                op_uns       <= req_funct3[2];
                op_off       <= req_addr[1:0];
            end else if (state == ACCESS && dmem_resp) begin
                dmem_read  <= 1'b0;
                dmem_write <= 1'b0;
                dmem_wmask <= 4'b0;
                dmem_wdata <= 32'b0;
                resp_valid <= 1'b1;
                resp_rdata <= op_load ? ld_data : 32'b0;
            end
            if (accept && mis) begin
                resp_valid      <= 1'b1;
                resp_misaligned <= 1'b1;
                resp_rdata      <= 32'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and randomized checks of dmem_access_unit against an arithmetic reference model
module tb_dmem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata, resp_rdata;
    logic        dmem_read, dmem_write, dmem_resp, resp_valid, resp_misaligned;
    logic [3:0]  dmem_wmask;

    int checks = 0;
    int errors = 0;

    logic        e_st, e_mis;
    logic [31:0] e_addr, e_mask, e_wd, e_rd, cur_rd;

    dmem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected behaviour from the architectural rules: access size in bytes, offset, sign
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd);
        int size, off;
        logic sgn;
        logic [31:0] bits, v;
        if (st) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        else size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
        sgn = !st && (f3 == 0 || f3 == 1);
        off = (size == 1) ? int'(a % 4) : (size == 2) ? int'((a % 4) / 2 * 2) : 0;
        e_st = st;
`ifdef DMEM_MISALIGN_TRAP_EN
        e_mis = (a % size) != 0;
`else
        e_mis = 1'b0;
`endif
        e_addr = a - (a % 4);
        e_mask = ((32'd1 << size) - 1) << off;
        e_wd = (size == 4) ? wd : (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : (wd & 32'hFF) * 32'h0101_0101;
        bits = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
        v = (rd >> (8 * off)) & bits;
        if (sgn && size < 4 && v > (bits >> 1)) v = v | ~bits;
        e_rd = st ? 32'd0 : v;
        cur_rd = rd;
    endtask

    // Present an op for one cycle from a negedge; leaves the bench at the next negedge
    task automatic start_op(input logic st, input logic ld, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        model(st, f3, a, wd, rd);
        req_valid = 1'b1; req_store = st; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk("ready_at_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    endtask

    // Hold the cache off for lat cycles, checking stable strobes, then respond
    task automatic finish_op(input int lat);
        for (int i = 0; i < lat; i++) begin
            chk("read_strobe", dmem_read, !e_st);
            chk("write_strobe", dmem_write, e_st);
            chk("address", dmem_address, e_addr);
            chk("wmask", dmem_wmask, e_st ? e_mask : 0);
            chk("wdata", dmem_wdata, e_st ? e_wd : 0);
            chk("ready_busy", req_ready, 0);
            chk("no_resp_in_access", resp_valid, 0);
            if (i == lat - 1) begin dmem_resp = 1'b1; dmem_rdata = cur_rd; end
            @(negedge clk);
        end
        dmem_resp = 1'b0; dmem_rdata = $urandom;
        chk("resp_valid", resp_valid, 1);
        chk("resp_rdata", resp_rdata, e_rd);
        chk("resp_misaligned", resp_misaligned, 0);
        chk("read_dropped", dmem_read, 0);
        chk("write_dropped", dmem_write, 0);
        chk("wmask_idle", dmem_wmask, 0);
        chk("wdata_idle", dmem_wdata, 0);
        chk("ready_resp", req_ready, 1);
    endtask

    task automatic finish_mis();
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_flag", resp_misaligned, 1);
        chk("mis_rdata", resp_rdata, 0);
        chk("mis_no_read", dmem_read, 0);
        chk("mis_no_write", dmem_write, 0);
    endtask

    task automatic finish_any(input int lat);
        if (e_mis) finish_mis();
        else finish_op(lat);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0; dmem_rdata = 32'b0; dmem_resp = 1'b0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_read", dmem_read, 0);
        chk("rst_write", dmem_write, 0);
        chk("rst_wmask", dmem_wmask, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_address", dmem_address, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_misaligned", resp_misaligned, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // neither load nor store: not accepted
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("no_op_ignored", dmem_read | dmem_write, 0);
        chk("no_op_ready", req_ready, 1);
        // stray response outside ACCESS
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("stray_resp", resp_valid, 0);
        // SB at 0x1003
        start_op(1, 0, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0);
        chk("sb_mask_lit", dmem_wmask, 4'b1000);
        chk("sb_wdata_lit", dmem_wdata, 32'hA5A5_A5A5);
        finish_op(1);
        @(negedge clk);
        chk("resp_one_cycle", resp_valid, 0);
        // loads at 0x2002
        start_op(0, 1, 3'b000, 32'h2002, 0, 32'h12F0_3456); finish_op(2);
        chk("lb_lit", resp_rdata, 32'hFFFF_FFF0);
        start_op(0, 1, 3'b100, 32'h2002, 0, 32'h12F0_3456); finish_op(1);
        chk("lbu_lit", resp_rdata, 32'h0000_00F0);
        start_op(0, 1, 3'b001, 32'h2002, 0, 32'h12F0_3456); finish_op(1);
        chk("lh_lit", resp_rdata, 32'h0000_12F0);
        start_op(0, 1, 3'b101, 32'h2002, 0, 32'h12F0_3456); finish_op(1);
        chk("lhu_lit", resp_rdata, 32'h0000_12F0);
        // back-to-back LW then SW from RESP, cache latency 3
        start_op(0, 1, 3'b010, 32'h2100, 0, 32'hCAFE_F00D); finish_op(3);
        start_op(1, 0, 3'b010, 32'h2104, 32'h1234_5678, 0);
        chk("b2b_no_idle", dmem_write, 1);
        finish_op(3);
        // strobe hold for 5 cycles; load and store both set -> store wins
        start_op(0, 1, 3'b001, 32'h2200, 0, 32'h8001_7FFF); finish_op(5);
        start_op(1, 1, 3'b001, 32'h2202, 32'hABCD_BEEF, 32'h5555_5555); finish_op(2);
        // LW at 0x3002
        start_op(0, 1, 3'b010, 32'h3002, 0, 32'h7654_3210);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_mis_trap", e_mis, 1);
        finish_mis();
`else
        chk("lw_mis_addr", dmem_address, 32'h3000);
        finish_op(2);
        chk("lw_mis_rdata", resp_rdata, 32'h7654_3210);
`endif
        @(negedge clk);
        // randomized ops, random latency, random idle gaps
        for (int n = 0; n < 60; n++) begin
            logic st;
            st = 1'($urandom_range(0, 1));
            start_op(st, !st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            finish_any($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rand_gap_no_resp", resp_valid, 0);
            end
        end
        @(negedge clk);
        // reset in ACCESS of a SW
        start_op(1, 0, 3'b010, 32'h4000, 32'hDEAD_BEEF, 0);
        chk("pre_rst_write", dmem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drops_write", dmem_write, 0);
        chk("rst_ready_now", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("late_resp_ignored", resp_valid, 0);
        chk("late_resp_no_write", dmem_write, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
